// File: rtl/sr_pkg.sv
// Shared types for the SR command path: FSM state encoding, {s,r} command codes
// and the priority pick used when both requests are pending.
package sr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } sr_state_e;

  localparam logic [1:0] SR_CMD_NOP     = 2'b00;
  localparam logic [1:0] SR_CMD_RST     = 2'b01;
  localparam logic [1:0] SR_CMD_SET     = 2'b10;
  localparam logic [1:0] SR_CMD_ILLEGAL = 2'b11;

  // Never returns SR_CMD_ILLEGAL: the loser of a conflict is simply not issued.
  function automatic logic [1:0] sr_pick(input logic set_p, input logic clr_p,
                                         input logic prio_set);
    if (set_p && (prio_set || !clr_p)) return SR_CMD_SET;
    if (clr_p)                         return SR_CMD_RST;
    return SR_CMD_NOP;
  endfunction

endpackage

// File: rtl/sr_debounce.sv
// Two-flop synchroniser plus debounce filter for one raw request line; rise is high
// in the cycle the filtered level is about to go 0->1.
module sr_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic rise
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic [1:0]    sync;
  logic          level;
  logic [CW-1:0] cnt;
  logic          differ;
  logic          done;

  assign differ = (sync[1] != level);
  assign done   = differ && (cnt == CW'(DB_CYCLES - 1));
  assign rise   = done && sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= '0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      // NOTE: non-blocking so each stage captures the value from before this edge.
      sync <= {sync[0], raw};
      if (!differ) begin
        cnt <= '0;
      end else if (done) begin
        cnt   <= '0;
        level <= sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sr_cmd_sequencer.sv
// Turns debounced set/clear request edges into single-cycle s/r pulses with a forced idle gap.
// Optional SR_CONFLICT_LOG_EN builds a saturating 8-bit conflict counter.
module sr_cmd_sequencer #(
  parameter int DB_CYCLES  = 4,
  parameter int GAP_CYCLES = 2,
  parameter bit PRIO_SET   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_req,
  input  logic       clr_req,
  output logic       s,
  output logic       r,
  output logic       busy,
  output logic       conflict,
  output logic [7:0] conflict_cnt
);

  import sr_pkg::*;

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  sr_state_e     state;
  logic          set_rise, clr_rise;
  logic          set_pend, clr_pend;
  logic [GW-1:0] gap_cnt;
  logic [1:0]    cmd;
  logic          hit;

  sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_set (
    .clk (clk),
    .rst (rst),
    .raw (set_req),
    .rise(set_rise)
  );

  sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
    .clk (clk),
    .rst (rst),
    .raw (clr_req),
    .rise(clr_rise)
  );

  assign cmd = sr_pick(set_pend, clr_pend, PRIO_SET);
  assign hit = (state == IDLE) && set_pend && clr_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      s        <= 1'b0;
      r        <= 1'b0;
      busy     <= 1'b0;
      conflict <= 1'b0;
      set_pend <= 1'b0;
      clr_pend <= 1'b0;
      gap_cnt  <= '0;
    end else begin
      s        <= 1'b0;
      r        <= 1'b0;
      conflict <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd != SR_CMD_NOP) begin
            {s, r}   <= cmd;
            conflict <= hit;
            busy     <= 1'b1;
            state    <= PULSE;
          end
        end
        PULSE: begin
          if (GAP_CYCLES > 0) begin
            gap_cnt <= GW'(GAP_CYCLES - 1);
            state   <= GAP;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase

      // IDLE serves or drops whatever is pending; a fresh edge in the same cycle still latches.
      if (state == IDLE) begin
        set_pend <= 1'b0;
        clr_pend <= 1'b0;
      end
      if (set_rise) set_pend <= 1'b1;
      if (clr_rise) clr_pend <= 1'b1;
    end
  end

`ifdef SR_CONFLICT_LOG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= 8'h00;
    end else if (hit && (conflict_cnt != 8'hFF)) begin
      conflict_cnt <= conflict_cnt + 8'h01;
    end
  end
`else
  assign conflict_cnt = 8'h00;
`endif

endmodule
